// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampled UART receiver (7/8 data bits, optional parity); data_ld pulses one clk after the mid-stop sample.
// No backpressure: each character is presented once. Define RX_SYNC_EN to add a 2-flop rx synchronizer (+2 clk latency).
module uart_rx_engine #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       even,
  output logic [7:0] rx_data,
  output logic       data_ld,
  output logic       busy,
  output logic       perr,
  output logic       ferr
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            eight_q, eight_d;
  logic            pen_q, pen_d;
  logic            even_q, even_d;
  logic            perr_pend_q, perr_pend_d;
  logic [7:0]      rx_data_d;
  logic            data_ld_d;
  logic            perr_d;
  logic            ferr_d;
  logic [2:0]      last_bit;

  assign last_bit = eight_q ? 3'd7 : 3'd6;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      eight_q     <= 1'b0;
      pen_q       <= 1'b0;
      even_q      <= 1'b0;
      perr_pend_q <= 1'b0;
      rx_data     <= 8'h00;
      data_ld     <= 1'b0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      eight_q     <= eight_d;
      pen_q       <= pen_d;
      even_q      <= even_d;
      perr_pend_q <= perr_pend_d;
      rx_data     <= rx_data_d;
      data_ld     <= data_ld_d;
      perr        <= perr_d;
      ferr        <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    eight_d     = eight_q;
    pen_d       = pen_q;
    even_d      = even_q;
    perr_pend_d = perr_pend_q;
    rx_data_d   = rx_data;
    data_ld_d   = 1'b0;
    perr_d      = perr;
    ferr_d      = ferr;

    case (state_q)
      IDLE: begin
        if (baud_tick && !rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (baud_tick) begin
          if (tick_q == HALF_LAST) begin
            tick_d = '0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              // Frame format is frozen here so mid-frame control changes cannot corrupt it.
              state_d     = DATA;
              bit_d       = '0;
              shift_d     = '0;
              par_d       = 1'b0;
              perr_pend_d = 1'b0;
              eight_d     = eight;
              pen_d       = pen;
              even_d      = even;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (tick_q == FULL_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[7:1]};
            par_d   = par_q ^ rx_s;
            bit_d   = bit_q + 3'd1;
            if (bit_q == last_bit) begin
              state_d = pen_q ? PARITY : STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (baud_tick) begin
          if (tick_q == FULL_LAST) begin
            tick_d      = '0;
            perr_pend_d = even_q ? (par_q ^ rx_s) : ~(par_q ^ rx_s);
            state_d     = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (tick_q == FULL_LAST) begin
            // A 7-bit character sits in shift_q[7:1] after seven right shifts.
            tick_d    = '0;
            state_d   = IDLE;
            data_ld_d = 1'b1;
            rx_data_d = eight_q ? shift_q : {1'b0, shift_q[7:1]};
            perr_d    = pen_q & perr_pend_q;
            ferr_d    = ~rx_s;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: OVERSAMPLE=16, baud_tick every 4 clk, so one bit lasts 64 clk.
module tb_uart_rx_engine;

  logic       clk;
  logic       reset;
  logic       baud_tick;
  logic       rx;
  logic       eight;
  logic       pen;
  logic       even;
  logic [7:0] rx_data;
  logic       data_ld;
  logic       busy;
  logic       perr;
  logic       ferr;

  int checks = 0;
  int errors = 0;
  int div    = 0;

  logic [7:0] got_data[$];
  logic       got_perr[$];
  logic       got_ferr[$];

  localparam int BIT_CLKS = 64;

  uart_rx_engine #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .rx        (rx),
    .eight     (eight),
    .pen       (pen),
    .even      (even),
    .rx_data   (rx_data),
    .data_ld   (data_ld),
    .busy      (busy),
    .perr      (perr),
    .ferr      (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (data_ld === 1'b1) begin
      got_data.push_back(rx_data);
      got_perr.push_back(perr);
      got_ferr.push_back(ferr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] data_at(input int i);
    return (i < got_data.size()) ? got_data[i] : 8'hxx;
  endfunction

  function automatic logic perr_at(input int i);
    return (i < got_perr.size()) ? got_perr[i] : 1'bx;
  endfunction

  function automatic logic ferr_at(input int i);
    return (i < got_ferr.size()) ? got_ferr[i] : 1'bx;
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic use_par,
                            input logic par_bit, input logic stop_bit, input logic flip);
    send_bit(1'b0);
    if (flip) begin
      eight = ~eight;
      pen   = ~pen;
      even  = ~even;
    end
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (use_par) send_bit(par_bit);
    send_bit(stop_bit);
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    eight = 1'b1;
    pen   = 1'b0;
    even  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_data_ld", 32'(data_ld), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_perr", 32'(perr), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    reset = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_count", 32'(got_data.size()), 32'd1);
    check("a5_data", 32'(data_at(0)), 32'hA5);
    check("a5_perr", 32'(perr_at(0)), 32'h0);
    check("a5_ferr", 32'(ferr_at(0)), 32'h0);
    check("a5_busy_after", 32'(busy), 32'h0);
    check("a5_held", 32'(rx_data), 32'hA5);
    repeat (BIT_CLKS) @(negedge clk);

    // 7E1 0x41: two ones, even parity bit 0 is correct, 1 is a parity error
    eight = 1'b0;
    pen   = 1'b1;
    even  = 1'b1;
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    check("7e1_ok_count", 32'(got_data.size()), 32'd2);
    check("7e1_ok_data", 32'(data_at(1)), 32'h41);
    check("7e1_ok_perr", 32'(perr_at(1)), 32'h0);
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0);
    check("7e1_bad_count", 32'(got_data.size()), 32'd3);
    check("7e1_bad_data", 32'(data_at(2)), 32'h41);
    check("7e1_bad_perr", 32'(perr_at(2)), 32'h1);
    check("7e1_bad_ferr", 32'(ferr_at(2)), 32'h0);
    repeat (BIT_CLKS) @(negedge clk);

    // 8N1 0x3C with stop bit forced low
    eight = 1'b1;
    pen   = 1'b0;
    even  = 1'b0;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("ferr_count", 32'(got_data.size()), 32'd4);
    check("ferr_data", 32'(data_at(3)), 32'h3C);
    check("ferr_flag", 32'(ferr_at(3)), 32'h1);
    check("ferr_perr", 32'(perr_at(3)), 32'h0);

    // False start: 4 ticks low, then high
    rx = 1'b0;
    repeat (16) @(negedge clk);
    check("false_busy_during", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (48) @(negedge clk);
    check("false_busy_after", 32'(busy), 32'h0);
    check("false_count", 32'(got_data.size()), 32'd4);
    check("false_rx_data_held", 32'(rx_data), 32'h3C);
    check("false_ferr_held", 32'(ferr), 32'h1);
    repeat (BIT_CLKS) @(negedge clk);

    // Reset during bit 3 of a 0xFF frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    check("midrst_data_ld", 32'(data_ld), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_perr", 32'(perr), 32'h0);
    check("midrst_ferr", 32'(ferr), 32'h0);
    reset = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("midrst_no_ld", 32'(got_data.size()), 32'd4);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check("after_rst_count", 32'(got_data.size()), 32'd5);
    check("after_rst_data", 32'(data_at(4)), 32'h5A);
    check("after_rst_ferr", 32'(ferr_at(4)), 32'h0);

    // Back-to-back 0x01 then 0xFF with no idle gap
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b_count", 32'(got_data.size()), 32'd7);
    check("b2b_first", 32'(data_at(5)), 32'h01);
    check("b2b_second", 32'(data_at(6)), 32'hFF);
    repeat (BIT_CLKS) @(negedge clk);

    // Format controls flipped to 7O1 after the start bit: frame stays 8N1
    eight = 1'b1;
    pen   = 1'b0;
    even  = 1'b1;
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    check("capture_count", 32'(got_data.size()), 32'd8);
    check("capture_data", 32'(data_at(7)), 32'h96);
    check("capture_perr", 32'(perr_at(7)), 32'h0);
    check("capture_ferr", 32'(ferr_at(7)), 32'h0);

    repeat (BIT_CLKS) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
